wt_ram_arbiter: RTL
===================

// Module: wt_ram_arbiter
// PURPOSE
//  Shares one wavetable RAM read port (RADDR/rbank/RDATA) between N_VOICES wavetable voices.
//  Round-robin grants one read per cycle and routes RDATA back to the voice that issued the read.
//  Forwards host wavetable-load writes to the RAM write port.
//  Holds a host write off when it would collide with a read issued in the same cycle.
//  Sits between the WAVETABLE voice instances and the banked block RAM.
// PARAMETERS
//  N_VOICES   4   number of voice requesters (2..8)
//  DATAWIDTH  16  sample width; `DATAWIDTH from shared defs
//  ADDRWIDTH  8   table address width; `ADDRWIDTH from shared defs
//  BANKWIDTH  2   wavetable bank select width
// PORTS
//  clk       in   1              single clock; all logic on posedge
//  rst       in   1              synchronous, active-high reset
//  v_req     in   N              per-voice read request (level; held until v_gnt)
//  v_raddr   in   N*ADDRWIDTH    per-voice table address, packed; voice i at [i*8 +: 8]
//  v_rbank   in   N*BANKWIDTH    per-voice bank select, packed
//  v_gnt     out  N              one-hot, 1-cycle pulse: read issued for voice i
//  v_rvalid  out  N              one-hot, 1-cycle pulse: v_rdata belongs to voice i
//  v_rdata   out  DATAWIDTH      returned sample, shared by all voices
//  RADDR     out  ADDRWIDTH      RAM read address (registered)
//  rbank     out  BANKWIDTH      RAM read bank (registered)
//  RE        out  1              RAM read enable (registered); RDATA valid the cycle after RE
//  RDATA     in   DATAWIDTH      RAM read data
//  w_req     in   1              host write request (level; held until w_ack)
//  w_addr/w_bank/w_data  in  ADDRWIDTH/BANKWIDTH/DATAWIDTH   host write address, bank and data
//  w_ack     out  1              1-cycle pulse: write issued to RAM
//  WADDR/wbank/WDATA/WE  out  ADDRWIDTH/BANKWIDTH/DATAWIDTH/1   RAM write port (registered)
// BEHAVIOUR
//  - Reset: v_gnt, v_rvalid, RE, WE and w_ack = 0.
//    RADDR, rbank, WADDR, wbank, WDATA and v_rdata = 0; RR pointer = 0.
//    A read in flight at reset is discarded; it gets no v_rvalid.
//  - Edge E0: pick the winner among eligible v_req.
//    Eligible = v_req[i] & ~v_gnt[i]; a just-granted voice is masked for one cycle.
//  - After E0: RE=1; RADDR/rbank = winner's address and bank; v_gnt[winner]=1.
//  - Edge E1: RDATA is sampled into v_rdata.
//    After E1: v_rvalid[winner]=1.
//    Read latency = 2 edges from sample to v_rvalid.
//  - Throughput: one read per cycle, back-to-back.
//    A 2-deep tag pipe tracks the winner index through to v_rvalid.
//  - No eligible request: RE=0; RADDR/rbank hold their last values.
//  - Round robin: the search starts at ptr and wraps N-1 -> 0.
//    After a grant to voice i, ptr = (i+1) mod N. With no grant, ptr holds.
//  - Voices must drop v_req in the cycle after they see v_gnt.
//    A v_req still high after that is a new request.
//  - Host write, normal case: after the edge sampling w_req, WE=1, WADDR/wbank/WDATA are loaded and w_ack=1.
//  - Host write collision: w_req is sampled and {w_bank,w_addr} equals the {rbank,RADDR} being issued with RE=1 on the same edge.
//    The write is deferred one cycle. The read returns the pre-write data.
//    At most one deferral per write: the following edge issues the write unconditionally.
//  - w_ack masks w_req for one cycle, same rule as v_gnt.
//  - Simultaneous read and write to different addresses proceed together. The ports are independent.
// CONFIGURATION
//  - WT_ARB_PRIO0_EN defined:
//    Voice 0 has fixed top priority and wins whenever eligible.
//    Voices 1..N-1 round-robin among themselves; ptr ignores voice-0 grants.
//  - WT_ARB_PRIO0_EN undefined: pure round robin over all N voices.
// STRUCTURE
//  - Shared defs include wt_defs.vh: `DATAWIDTH, `ADDRWIDTH, BANKWIDTH.
//    Also the N_VOICES maximum and the clog2-based tag width.
//  - Sub-module wt_rr_pick: combinational N-way round-robin picker.
//    Inputs eligible and ptr; outputs one-hot grant, index and any-grant.
//    The top level owns ptr, the tag pipe, the collision logic and all registers.
// TESTING (N_VOICES=4, RAM model returns RDATA = {rbank,RADDR} one cycle after RE)
//  1. Single read: reset, then v_req[2] with addr 8'h10, bank 1 for one cycle.
//     -> v_gnt=4'b0100 after E0; RE=1, RADDR=8'h10.
//     -> v_rvalid=4'b0100 after E1; v_rdata=16'h0110.
//  2. Round robin: all 4 v_req held high.
//     -> grants cycle 0,1,2,3,0...; no voice is granted twice within any 4 grants.
//     -> v_rvalid follows v_gnt by exactly 1 cycle.
//  3. Collision: w_req with bank 1, addr 8'h10, data 16'hBEEF on the same edge as the read in case 1.
//     -> WE stays 0 on that edge; WE=1 and w_ack=1 one cycle later.
//     -> The read returns 16'h0110.
//  4. No collision: the write uses addr 8'h11 in the same setup.
//     -> WE=1 and w_ack=1 on the same edge as RE.
//  5. Reset mid-flight: assert rst on the edge after a grant.
//     -> no v_rvalid; all outputs 0; ptr=0; next grant goes to the lowest requesting voice.
//  6. With WT_ARB_PRIO0_EN, all v_req high.
//     -> voice 0 takes every other cycle; voices 1,2,3 round-robin in the remaining slots.

Source files
------------

// File: rtl/wt_ram_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wt_ram_arbiter_pkg
//   Shared definitions for the wavetable RAM arbiter slice.
//
//   Contents:
//     WT_DATAWIDTH   default sample width
//     WT_ADDRWIDTH   default table address width
//     WT_BANKWIDTH   default wavetable bank select width
//     WT_MAX_VOICES  largest number of voices the arbiter is meant to serve
//     wrState_e      host write path state (idle / one-cycle deferral)
//     tagWidth()     width of a voice index for a given voice count
// ----------------------------------------------------------------------------
package wt_ram_arbiter_pkg;

    localparam int WT_DATAWIDTH  = 16;
    localparam int WT_ADDRWIDTH  = 8;
    localparam int WT_BANKWIDTH  = 2;
    localparam int WT_MAX_VOICES = 8;

    // The host write path only ever needs to remember whether the write at
    // the head of the queue has already been pushed back once.
    typedef enum logic {
        WR_IDLE  = 1'b0,
        WR_DEFER = 1'b1
    } wrState_e;

    // Voice index width; never narrower than one bit so a two-voice build
    // still has a usable tag and pointer.
    function automatic int tagWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/wt_ram_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// wt_rr_pick
//   Purely combinational N-way round-robin picker. Starting at ptr_i and
//   wrapping from N-1 back to 0, it selects the first set bit of eligible_i.
//
//   Ports:
//     eligible_i  [N-1:0]     requesters allowed to win this cycle
//     ptr_i       [IDXW-1:0]  index where the search begins
//     gnt_o       [N-1:0]     one-hot winner (all zero when nobody is eligible)
//     idx_o       [IDXW-1:0]  binary index of the winner (0 when none)
//     any_o                   at least one requester won
// ----------------------------------------------------------------------------
module wt_rr_pick #(
    parameter int N    = 4,
    parameter int IDXW = 2
) (
    input  logic [N-1:0]    eligible_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IDXW-1:0] idx_o,
    output logic            any_o
);

    // Walk the requesters in priority order from ptr_i; the first one seen
    // wins and the any_o flag blocks everyone behind it.
    always_comb begin : pickLoop
        logic [IDXW-1:0] cand;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDXW'((int'(ptr_i) + k) % N);
            if (!any_o && eligible_i[cand]) begin
                any_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/wt_ram_arbiter.sv
// ----------------------------------------------------------------------------
// wt_ram_arbiter
//   Shares one wavetable RAM read port between N_VOICES voices and forwards
//   host wavetable-load writes to the RAM write port.
//
//   Reads: one grant per cycle, round robin. The winner's address and bank
//   are registered onto RADDR_o/rbank_o with RE_o, v_gnt_o pulses for the
//   winner, and one edge later RDATA_i is captured into v_rdata_o while
//   v_rvalid_o pulses for that same voice.
//
//   Writes: a sampled w_req_i is normally issued straight away (WE_o, w_ack_o).
//   When it targets exactly the {bank,address} being read on that same edge
//   it is held back one cycle so the read sees the old contents; the
//   following edge issues it without further checks.
//
//   Configuration macro: WT_ARB_PRIO0_EN
//     defined   : voice 0 has fixed top priority, voices 1..N-1 round robin
//     undefined : plain round robin over all voices
//
//   Ports:
//     clk_i, rst_i                 clock, synchronous active-high reset
//     v_req_i    [N]               per-voice read request (level)
//     v_raddr_i  [N*ADDRWIDTH]     packed per-voice addresses, voice i at [i*ADDRWIDTH +: ADDRWIDTH]
//     v_rbank_i  [N*BANKWIDTH]     packed per-voice bank selects
//     v_gnt_o    [N]               one-hot read-issued pulse
//     v_rvalid_o [N]               one-hot data-valid pulse
//     v_rdata_o  [DATAWIDTH]       returned sample, shared
//     RADDR_o, rbank_o, RE_o       RAM read port (registered)
//     RDATA_i                      RAM read data, valid the cycle RE_o is high
//     w_req_i, w_addr_i, w_bank_i, w_data_i   host write request (level)
//     w_ack_o                      write-issued pulse
//     WADDR_o, wbank_o, WDATA_o, WE_o          RAM write port (registered)
// ----------------------------------------------------------------------------
module wt_ram_arbiter
    import wt_ram_arbiter_pkg::*;
#(
    parameter int N_VOICES  = 4,
    parameter int DATAWIDTH = WT_DATAWIDTH,
    parameter int ADDRWIDTH = WT_ADDRWIDTH,
    parameter int BANKWIDTH = WT_BANKWIDTH
) (
    input  logic                           clk_i,
    input  logic                           rst_i,

    input  logic [N_VOICES-1:0]            v_req_i,
    input  logic [N_VOICES*ADDRWIDTH-1:0]  v_raddr_i,
    input  logic [N_VOICES*BANKWIDTH-1:0]  v_rbank_i,
    output logic [N_VOICES-1:0]            v_gnt_o,
    output logic [N_VOICES-1:0]            v_rvalid_o,
    output logic [DATAWIDTH-1:0]           v_rdata_o,

    output logic [ADDRWIDTH-1:0]           RADDR_o,
    output logic [BANKWIDTH-1:0]           rbank_o,
    output logic                           RE_o,
    input  logic [DATAWIDTH-1:0]           RDATA_i,

    input  logic                           w_req_i,
    input  logic [ADDRWIDTH-1:0]           w_addr_i,
    input  logic [BANKWIDTH-1:0]           w_bank_i,
    input  logic [DATAWIDTH-1:0]           w_data_i,
    output logic                           w_ack_o,

    output logic [ADDRWIDTH-1:0]           WADDR_o,
    output logic [BANKWIDTH-1:0]           wbank_o,
    output logic [DATAWIDTH-1:0]           WDATA_o,
    output logic                           WE_o
);

    localparam int TAGW = tagWidth(N_VOICES);
    localparam logic [N_VOICES-1:0] ONE_HOT0 = {{(N_VOICES-1){1'b0}}, 1'b1};

    // Read-side state
    logic [N_VOICES-1:0]  vGnt_q;
    logic [N_VOICES-1:0]  vRvalid_q;
    logic [DATAWIDTH-1:0] vRdata_q;
    logic [ADDRWIDTH-1:0] raddr_q;
    logic [BANKWIDTH-1:0] rbank_q;
    logic                 re_q;
    logic [TAGW-1:0]      tag_q;
    logic [TAGW-1:0]      ptr_q;
    logic [TAGW-1:0]      ptr_d;

    // Write-side state
    wrState_e             wrState_q;
    logic                 wAck_q;
    logic                 we_q;
    logic [ADDRWIDTH-1:0] waddr_q;
    logic [BANKWIDTH-1:0] wbank_q;
    logic [DATAWIDTH-1:0] wdata_q;

    // Arbitration nets
    logic [N_VOICES-1:0]  eligible;
    logic [N_VOICES-1:0]  pickElig;
    logic [N_VOICES-1:0]  pickGnt;
    logic [TAGW-1:0]      pickIdx;
    logic                 pickAny;
    logic [N_VOICES-1:0]  winGnt;
    logic [TAGW-1:0]      winIdx;
    logic                 winAny;
    logic [ADDRWIDTH-1:0] winAddr;
    logic [BANKWIDTH-1:0] winBank;

    // Write-path nets
    logic                 wElig;
    logic                 addrHit;

    // A voice that was granted last cycle still has its request up while it
    // reacts to the grant, so it sits out one cycle to avoid a double read.
    assign eligible = v_req_i & ~vGnt_q;

    // In priority mode voice 0 is handled outside the rotating picker so the
    // pointer only ever reflects the round robin among voices 1..N-1.
    always_comb begin
        pickElig = eligible;
`ifdef WT_ARB_PRIO0_EN
        pickElig[0] = 1'b0;
`endif
    end

    wt_rr_pick #(
        .N    (N_VOICES),
        .IDXW (TAGW)
    ) rrPick (
        .eligible_i (pickElig),
        .ptr_i      (ptr_q),
        .gnt_o      (pickGnt),
        .idx_o      (pickIdx),
        .any_o      (pickAny)
    );

    // Final winner selection and the next round-robin pointer. The pointer
    // moves past whoever the rotating picker chose and holds otherwise.
    always_comb begin
        winGnt = pickGnt;
        winIdx = pickIdx;
        winAny = pickAny;
        ptr_d  = ptr_q;
`ifdef WT_ARB_PRIO0_EN
        if (eligible[0]) begin
            winGnt = ONE_HOT0;
            winIdx = '0;
            winAny = 1'b1;
        end else if (pickAny) begin
            ptr_d = (pickIdx == TAGW'(N_VOICES - 1)) ? '0 : pickIdx + TAGW'(1);
        end
`else
        if (pickAny) begin
            ptr_d = (pickIdx == TAGW'(N_VOICES - 1)) ? '0 : pickIdx + TAGW'(1);
        end
`endif
    end

    assign winAddr = v_raddr_i[winIdx*ADDRWIDTH +: ADDRWIDTH];
    assign winBank = v_rbank_i[winIdx*BANKWIDTH +: BANKWIDTH];

    // The ack pulse masks the still-high request for one cycle, and a write
    // only collides with a read issued on the very same edge.
    assign wElig   = w_req_i & ~wAck_q;
    assign addrHit = winAny && ({w_bank_i, w_addr_i} == {winBank, winAddr});

    // Read issue stage: register the winner onto the RAM read port and keep
    // its index as the tag for the data coming back one edge later.
    // Return stage: capture RDATA and decode the tag into the valid pulse.
    // The address registers deliberately hold when no read is issued.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vGnt_q    <= '0;
            re_q      <= 1'b0;
            raddr_q   <= '0;
            rbank_q   <= '0;
            tag_q     <= '0;
            ptr_q     <= '0;
            vRvalid_q <= '0;
            vRdata_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            re_q  <= winAny;
            if (winAny) begin
                vGnt_q  <= winGnt;
                raddr_q <= winAddr;
                rbank_q <= winBank;
                tag_q   <= winIdx;
            end else begin
                vGnt_q  <= '0;
            end

            if (re_q) begin
                vRdata_q  <= RDATA_i;
                vRvalid_q <= ONE_HOT0 << tag_q;
            end else begin
                vRvalid_q <= '0;
            end
        end
    end

    // Host write FSM. From idle a write either goes out immediately or, on
    // an exact address collision with the read being issued, is parked for
    // one cycle. A parked write is released on the next edge regardless of
    // what the read port is doing, so a write is delayed at most once.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wrState_q <= WR_IDLE;
            wAck_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wbank_q   <= '0;
            wdata_q   <= '0;
        end else begin
            case (wrState_q)
                WR_IDLE: begin
                    if (wElig && addrHit) begin
                        wrState_q <= WR_DEFER;
                        wAck_q    <= 1'b0;
                        we_q      <= 1'b0;
                    end else if (wElig) begin
                        wAck_q    <= 1'b1;
                        we_q      <= 1'b1;
                        waddr_q   <= w_addr_i;
                        wbank_q   <= w_bank_i;
                        wdata_q   <= w_data_i;
                    end else begin
                        wAck_q    <= 1'b0;
                        we_q      <= 1'b0;
                    end
                end
                WR_DEFER: begin
                    wrState_q <= WR_IDLE;
                    wAck_q    <= 1'b1;
                    we_q      <= 1'b1;
                    waddr_q   <= w_addr_i;
                    wbank_q   <= w_bank_i;
                    wdata_q   <= w_data_i;
                end
                default: begin
                    wrState_q <= WR_IDLE;
                    wAck_q    <= 1'b0;
                    we_q      <= 1'b0;
                end
            endcase
        end
    end

    assign v_gnt_o    = vGnt_q;
    assign v_rvalid_o = vRvalid_q;
    assign v_rdata_o  = vRdata_q;
    assign RADDR_o    = raddr_q;
    assign rbank_o    = rbank_q;
    assign RE_o       = re_q;
    assign w_ack_o    = wAck_q;
    assign WADDR_o    = waddr_q;
    assign wbank_o    = wbank_q;
    assign WDATA_o    = wdata_q;
    assign WE_o       = we_q;

endmodule
